fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Owns the program counter and drives instr_ptr into instr_cache.
//  Accepts each instruction the cache reports valid and forwards it, with
//  its address, to the decode/execute stage over a valid/ready handshake.
//  Handles branch redirects from execute, including a redirect that arrives
//  while a cache fetch is still outstanding.
// PARAMETERS
//  ADDR_BITS    16  instruction address width (byte address)
//  INSTR_BITS   32  instruction width
//  INSTR_BYTES  4   PC increment per sequential instruction
//  RESET_ADDR   0   PC value loaded on reset
// PORTS
//  clk            in   1           system clock
//  rst            in   1           synchronous, active-high reset
//  instr_ptr      out  ADDR_BITS   address requested from instr_cache (registered)
//  cache_valid    in   1           instr_cache valid
//  cache_instr    in   INSTR_BITS  instr_cache instruction
//  out_valid      out  1           out_instr/out_addr hold an instruction
//  out_ready      in   1           consumer accepts this cycle
//  out_instr      out  INSTR_BITS  instruction to decode
//  out_addr       out  ADDR_BITS   address of out_instr
//  redirect_en    in   1           branch taken; one-cycle pulse
//  redirect_addr  in   ADDR_BITS   branch target; low 2 bits cleared internally
// BEHAVIOUR
//  Clocking: one clock, clk. Reset: rst is synchronous and active-high.
//  Reset values: instr_ptr=RESET_ADDR, out_valid=0, out_instr=0, out_addr=0,
//   pending=0, state=S_RESYNC.
//  Cache contract: instr_ptr changes only in a cycle with cache_valid=1 (cache idle).
//   The cache drops valid one cycle after it sees the new address.
//  FSM states:
//   S_RESYNC: cache is not reset by rst and may hold a stale fetch.
//    Wait for cache_valid=1 and discard that word -> S_GUARD.
//   S_GUARD: exactly one cycle. cache_valid is ignored (stale data for the
//    old pointer) -> S_WAIT.
//   S_WAIT: a word is usable when cache_valid=1.
//  Accept, in S_WAIT with cache_valid=1 and slot free:
//   - Slot free means out_valid=0, or out_valid & out_ready this cycle.
//   - Actions: out_instr<=cache_instr, out_addr<=instr_ptr, out_valid<=1.
//   - instr_ptr <= instr_ptr+INSTR_BYTES, wrapping mod 2^ADDR_BITS -> S_GUARD.
//   - Throughput: one instruction per 2 cycles at best. Latency: cache_valid
//     to out_valid is 1 cycle.
//  Slot full and out_ready=0: hold instr_ptr, stay in S_WAIT. The cache keeps
//   the word valid.
//  Redirect (redirect_en=1):
//   - out_valid<=0 next cycle (flush).
//   - Same-cycle out_valid & out_ready counts as transferred before the flush.
//   - In S_WAIT with cache_valid=1: instr_ptr<=target -> S_GUARD. The word is
//     discarded.
//   - Otherwise: latch target, pending<=1. A later redirect overwrites the
//     target; last one wins.
//  Pending=1, S_WAIT, cache_valid=1: discard the word, instr_ptr<=pending
//   target, pending<=0 -> S_GUARD.
//  Redirect + accept in the same cycle: redirect wins and no instruction is
//   emitted. Redirect during S_GUARD or S_RESYNC follows the pending path.
//  rst mid-operation: restores reset values on the next edge. pending is
//   dropped and out_valid falls even if out_ready=0.
// TESTING
//  1 Reset, then the cache returns 0xAAAA0000 and holds valid (same addr) ->
//    the RESYNC word is discarded; out_instr=0xAAAA0000, out_addr=0x0000,
//    instr_ptr->0x0004.
//  2 Stream with out_ready=1 and cache_valid asserted 2 cycles after each
//    pointer change -> out_addr sequence 0,4,8,C; guard cycles never emit a
//    stale word.
//  3 out_ready=0 for 5 cycles with a full slot -> instr_ptr, out_instr and
//    out_addr are stable; no word is lost or duplicated when out_ready rises.
//  4 redirect_en, target 0x0102, while cache_valid=0 (fetch outstanding) ->
//    the returning word is discarded; next out_addr=0x0100; out_valid=0
//    meanwhile.
//  5 redirect 0x0200 then redirect 0x0300 before the cache returns ->
//    out_addr=0x0300; redirect in the same cycle as out handshake -> the old
//    instruction is counted once.
//  6 instr_ptr=0xFFFC accepted -> instr_ptr=0x0000 next; rst asserted with
//    out_valid=1, out_ready=0 -> out_valid=0 and instr_ptr=RESET_ADDR after
//    one edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch stage: owns the program counter, drives the instruction cache pointer and
// hands each usable cache word, with its address, to decode over valid/ready.
module fetch_unit #(
    parameter int                   ADDR_BITS   = 16,
    parameter int                   INSTR_BITS  = 32,
    parameter int                   INSTR_BYTES = 4,
    parameter logic [ADDR_BITS-1:0] RESET_ADDR  = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic [ADDR_BITS-1:0]  o_instr_ptr,
    input  logic                  i_cache_valid,
    input  logic [INSTR_BITS-1:0] i_cache_instr,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [INSTR_BITS-1:0] o_out_instr,
    output logic [ADDR_BITS-1:0]  o_out_addr,
    input  logic                  i_redirect_en,
    input  logic [ADDR_BITS-1:0]  i_redirect_addr
);

    typedef enum logic [1:0] {
        S_RESYNC,
        S_GUARD,
        S_WAIT
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic [ADDR_BITS-1:0]  r_instrPtr;
    logic [ADDR_BITS-1:0]  w_instrPtrNext;
    logic                  r_pending;
    logic                  w_pendingNext;
    logic [ADDR_BITS-1:0]  r_pendingAddr;
    logic [ADDR_BITS-1:0]  w_pendingAddrNext;
    logic                  r_outValid;
    logic                  w_outValidNext;
    logic [INSTR_BITS-1:0] r_outInstr;
    logic [INSTR_BITS-1:0] w_outInstrNext;
    logic [ADDR_BITS-1:0]  r_outAddr;
    logic [ADDR_BITS-1:0]  w_outAddrNext;

    logic                  w_slotFree;
    logic                  w_wordUsable;
    logic [ADDR_BITS-1:0]  w_target;

    // Targets are word aligned; the low address bits are simply masked off.
    assign w_target     = i_redirect_addr & ~ADDR_BITS'(3);
    assign w_slotFree   = !r_outValid || i_out_ready;
    assign w_wordUsable = (r_state == S_WAIT) && i_cache_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_RESYNC;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_instrPtr    <= RESET_ADDR;
            r_pending     <= 1'b0;
            r_pendingAddr <= '0;
            r_outValid    <= 1'b0;
            r_outInstr    <= '0;
            r_outAddr     <= '0;
        end else begin
            r_instrPtr    <= w_instrPtrNext;
            r_pending     <= w_pendingNext;
            r_pendingAddr <= w_pendingAddrNext;
            r_outValid    <= w_outValidNext;
            r_outInstr    <= w_outInstrNext;
            r_outAddr     <= w_outAddrNext;
        end
    end

    always_comb begin
        w_stateNext       = r_state;
        w_instrPtrNext    = r_instrPtr;
        w_pendingNext     = r_pending;
        w_pendingAddrNext = r_pendingAddr;
        w_outValidNext    = r_outValid && !i_out_ready;
        w_outInstrNext    = r_outInstr;
        w_outAddrNext     = r_outAddr;

        case (r_state)
            S_RESYNC: begin
                if (i_cache_valid) begin
                    w_stateNext = S_GUARD;
                end
            end
            S_GUARD: begin
                w_stateNext = S_WAIT;
            end
            S_WAIT: begin
                // A redirect or a pending redirect steals the word instead of emitting it.
                if (i_cache_valid) begin
                    if (i_redirect_en) begin
                        w_instrPtrNext = w_target;
                        w_pendingNext  = 1'b0;
                        w_stateNext    = S_GUARD;
                    end else if (r_pending) begin
                        w_instrPtrNext = r_pendingAddr;
                        w_pendingNext  = 1'b0;
                        w_stateNext    = S_GUARD;
                    end else if (w_slotFree) begin
                        w_outValidNext = 1'b1;
                        w_outInstrNext = i_cache_instr;
                        w_outAddrNext  = r_instrPtr;
                        w_instrPtrNext = r_instrPtr + ADDR_BITS'(INSTR_BYTES);
                        w_stateNext    = S_GUARD;
                    end
                end
            end
            default: begin
                w_stateNext = S_RESYNC;
            end
        endcase

        if (i_redirect_en) begin
            w_outValidNext = 1'b0;
            if (!w_wordUsable) begin
                w_pendingNext     = 1'b1;
                w_pendingAddrNext = w_target;
            end
        end
    end

    assign o_instr_ptr = r_instrPtr;
    assign o_out_valid = r_outValid;
    assign o_out_instr = r_outInstr;
    assign o_out_addr  = r_outAddr;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a behavioural cache, directed scenarios and random traffic,
// with a scoreboard of expected (address, instruction) pairs checked by a monitor.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr_ptr;
    logic        cache_valid = 1'b1;
    logic [31:0] cache_instr = 32'hDEADBEEF;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [15:0] out_addr;
    logic        redirect_en;
    logic [15:0] redirect_addr;

    int nAssert    = 0;
    int nFail      = 0;
    int nHandshake = 0;

    int cacheLatMin = 0;
    int cacheLatMax = 0;

    fetch_unit #(
        .ADDR_BITS  (16),
        .INSTR_BITS (32),
        .INSTR_BYTES(4),
        .RESET_ADDR (16'h0000)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .o_instr_ptr    (instr_ptr),
        .i_cache_valid  (cache_valid),
        .i_cache_instr  (cache_instr),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_instr    (out_instr),
        .o_out_addr     (out_addr),
        .i_redirect_en  (redirect_en),
        .i_redirect_addr(redirect_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wordAt(input logic [15:0] a);
        return {a ^ 16'hAAAA, a};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nAssert++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural cache: drops valid the cycle after it sees a new pointer, then
    // returns wordAt(pointer) after a random extra latency and holds it valid.
    logic [15:0] seenPtr   = 16'hBEEF;
    int          cacheWait = 0;
    always @(posedge clk) begin
        if (instr_ptr !== seenPtr) begin
            seenPtr     <= instr_ptr;
            cache_valid <= 1'b0;
            cacheWait   <= int'($urandom_range(cacheLatMax, cacheLatMin));
        end else if (cacheWait > 0) begin
            cacheWait <= cacheWait - 1;
        end else begin
            cache_valid <= 1'b1;
            cache_instr <= wordAt(seenPtr);
        end
    end

    // Reference model: after reset or a redirect the consumer must see the plain
    // sequential word stream from the (aligned) start address, nothing else.
    logic        reloadReq  = 1'b0;
    logic [15:0] reloadAddr = 16'h0000;
    logic        rstPrev    = 1'b1;
    logic        cvPrev     = 1'b0;
    logic [15:0] ptrPrev    = 16'h0000;
    logic [15:0] expQ[$];

    always @(posedge clk) begin
        reloadReq  <= rst || redirect_en;
        reloadAddr <= rst ? 16'h0000 : (redirect_addr & 16'hFFFC);
        rstPrev    <= rst;
        cvPrev     <= cache_valid;
        ptrPrev    <= instr_ptr;
    end

    always @(negedge clk) begin
        if (reloadReq) begin
            expQ.delete();
            for (int i = 0; i < 64; i++) begin
                expQ.push_back(reloadAddr + 16'(4 * i));
            end
            checkOutput("flush_valid", {31'b0, out_valid}, 32'd0);
        end
        if (!rstPrev && (instr_ptr !== ptrPrev)) begin
            checkOutput("ptr_change_cache_idle", {31'b0, cvPrev}, 32'd1);
        end
        if (out_valid && out_ready) begin
            nHandshake++;
            if (expQ.size() == 0) begin
                nAssert++;
                nFail++;
                $display("[TB] FAIL sb_empty: got addr %h expected no transfer", out_addr);
            end else begin
                logic [15:0] e;
                e = expQ.pop_front();
                checkOutput("sb_addr", {16'b0, out_addr}, {16'b0, e});
                checkOutput("sb_instr", out_instr, wordAt(e));
            end
        end
    end

    task automatic applyStimulus(input logic rs, input logic rdy, input logic rdEn, input logic [15:0] rdAddr);
        @(posedge clk);
        #1;
        rst           = rs;
        out_ready     = rdy;
        redirect_en   = rdEn;
        redirect_addr = rdAddr;
    endtask

    task automatic waitOut(input string name, input int maxCycles);
        for (int i = 0; i < maxCycles; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) break;
        end
        checkOutput(name, {31'b0, out_valid}, 32'd1);
    endtask

    task automatic waitCacheBusy(input int maxCycles);
        for (int i = 0; i < maxCycles; i++) begin
            @(posedge clk);
            #1;
            if (!cache_valid) break;
        end
    endtask

    initial begin
        int base;
        rst           = 1'b1;
        out_ready     = 1'b0;
        redirect_en   = 1'b0;
        redirect_addr = 16'h0000;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_instr_ptr", {16'b0, instr_ptr}, 32'h0000);
        checkOutput("rst_out_instr", out_instr, 32'h0);
        checkOutput("rst_out_addr", {16'b0, out_addr}, 32'h0000);
        rst = 1'b0;

        // Cache already holds the word for 0: the resync copy is dropped, then taken.
        waitOut("t1_valid", 10);
        checkOutput("t1_out_instr", out_instr, 32'hAAAA0000);
        checkOutput("t1_out_addr", {16'b0, out_addr}, 32'h0000);
        checkOutput("t1_instr_ptr", {16'b0, instr_ptr}, 32'h0004);

        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
            checkOutput("t3_hold_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("t3_hold_addr", {16'b0, out_addr}, 32'h0000);
            checkOutput("t3_hold_instr", out_instr, wordAt(16'h0000));
            checkOutput("t3_hold_ptr", {16'b0, instr_ptr}, 32'h0004);
        end

        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            waitOut("t2_valid", 12);
            checkOutput("t2_out_addr", {16'b0, out_addr}, 32'(4 * k));
        end

        // Redirect while the fetch is outstanding.
        cacheLatMin = 3;
        cacheLatMax = 3;
        waitCacheBusy(20);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0102);
        redirect_en = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        checkOutput("t4_flushed", {31'b0, out_valid}, 32'd0);
        waitOut("t4_valid", 30);
        checkOutput("t4_out_addr", {16'b0, out_addr}, 32'h0100);

        // Two redirects before the cache returns: the later target wins.
        waitCacheBusy(20);
        redirect_en   = 1'b1;
        redirect_addr = 16'h0200;
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0300);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        base = nHandshake;
        waitOut("t5_valid", 30);
        checkOutput("t5_out_addr", {16'b0, out_addr}, 32'h0300);
        redirect_en   = 1'b1;
        redirect_addr = 16'h0400;
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        waitOut("t5_valid2", 30);
        checkOutput("t5_after_addr", {16'b0, out_addr}, 32'h0400);
        checkOutput("t5_count_once", 32'(nHandshake - base), 32'd1);

        // Pointer wrap, then reset with a full, stalled slot.
        cacheLatMin = 0;
        cacheLatMax = 0;
        redirect_en   = 1'b1;
        redirect_addr = 16'hFFF8;
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        waitOut("t6_valid_fff8", 30);
        checkOutput("t6_addr_fff8", {16'b0, out_addr}, 32'hFFF8);
        waitOut("t6_valid_fffc", 30);
        checkOutput("t6_addr_fffc", {16'b0, out_addr}, 32'hFFFC);
        checkOutput("t6_ptr_wrap", {16'b0, instr_ptr}, 32'h0000);
        out_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput("t6_slot_full", {31'b0, out_valid}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput("t6_rst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("t6_rst_ptr", {16'b0, instr_ptr}, 32'h0000);
        checkOutput("t6_rst_instr", out_instr, 32'h0);
        checkOutput("t6_rst_addr", {16'b0, out_addr}, 32'h0000);

        // Random traffic: stalls, redirects, occasional resets, varying cache latency.
        cacheLatMax = 3;
        base = nHandshake;
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(99, 0));
            applyStimulus(r == 99, $urandom_range(3, 0) != 0, r < 4, 16'($urandom));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("random_progress", {31'b0, (nHandshake - base) > 200}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
